airlock_seq: RTL and testbench

- Parametrised airlock sequencer: door interlock FSM plus internal seconds prescaler and a single shared countdown.
- Replaces the fixed-duration interlock-plus-three-timers arrangement.
- Chamber states: dry (inner door usable) and flooded (outer door usable). Fill and drain transitions are separated by a settling wait.
- Drives door enables, phase flags and a remaining-seconds value for the HEX display logic.

---
 rtl/airlock_seq.sv | 166 ++++++++++++++++
 tb/tb_airlock_seq.sv | 330 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/airlock_seq.sv
// airlock_seq: airlock door interlock sequencer with a seconds prescaler
// and one shared countdown for the wait, fill and drain phases.
// Optional feature macro: AIRLOCK_SEQ_FAULT_EN. When it is defined, a door
// switch raised during WAIT/FILL/DRAIN latches FAULT until reset.
module airlock_seq #(
    parameter int unsigned TICK_DIV   = 50000000,
    parameter int unsigned WAIT_SECS  = 5,
    parameter int unsigned FILL_SECS  = 7,
    parameter int unsigned DRAIN_SECS = 8,
    parameter int unsigned CNT_W      = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             fill_req,
    input  logic             drain_req,
    input  logic             abort,
    input  logic             hold,
    input  logic             inner_sw,
    input  logic             outer_sw,
    output logic             inner_door,
    output logic             outer_door,
    output logic             waiting,
    output logic             filling,
    output logic             draining,
    output logic [CNT_W-1:0] remaining,
    output logic             done,
    output logic [2:0]       state
);

    localparam int unsigned PRE_W = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam logic [PRE_W-1:0] PRE_MAX  = PRE_W'(TICK_DIV - 1);
    localparam logic [CNT_W-1:0] WAIT_LD  = CNT_W'(WAIT_SECS);
    localparam logic [CNT_W-1:0] FILL_LD  = CNT_W'(FILL_SECS);
    localparam logic [CNT_W-1:0] DRAIN_LD = CNT_W'(DRAIN_SECS);
    localparam logic [CNT_W-1:0] REM_ONE  = CNT_W'(1);

    typedef enum logic [2:0] {
        S_IDLE    = 3'd0,
        S_WAIT    = 3'd1,
        S_FILL    = 3'd2,
        S_FLOODED = 3'd3,
        S_DRAIN   = 3'd4,
        S_FAULT   = 3'd5
    } state_t;

    state_t             state_q, state_d;
    logic               dir_q, dir_d;       // 0: heading to FILL, 1: heading to DRAIN
    logic [PRE_W-1:0]   pre_q, pre_d;
    logic [CNT_W-1:0]   rem_q, rem_d;
    logic               done_q, done_d;
    logic               timed;
    logic               tick;
    logic               expire;

    // State and datapath registers, cleared asynchronously.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= S_IDLE;
            dir_q   <= 1'b0;
            pre_q   <= '0;
            rem_q   <= '0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            dir_q   <= dir_d;
            pre_q   <= pre_d;
            rem_q   <= rem_d;
            done_q  <= done_d;
        end
    end

    // Next-state, prescaler and countdown logic.
    always_comb begin
        state_d = state_q;
        dir_d   = dir_q;
        pre_d   = pre_q;
        rem_d   = rem_q;
        done_d  = 1'b0;
        timed   = (state_q == S_WAIT) || (state_q == S_FILL) || (state_q == S_DRAIN);
        tick    = timed && !hold && (pre_q == PRE_MAX);
        expire  = tick && (rem_q == REM_ONE);

        if (timed && !hold) begin
            pre_d = tick ? '0 : pre_q + PRE_W'(1);
        end
        if (tick) begin
            rem_d = rem_q - REM_ONE;
        end

        case (state_q)
            S_IDLE: begin
                if (fill_req && !inner_sw && !outer_sw) begin
                    state_d = S_WAIT;
                    dir_d   = 1'b0;
                    rem_d   = WAIT_LD;
                    pre_d   = '0;
                end
            end
            S_FLOODED: begin
                if (drain_req && !inner_sw && !outer_sw) begin
                    state_d = S_WAIT;
                    dir_d   = 1'b1;
                    rem_d   = WAIT_LD;
                    pre_d   = '0;
                end
            end
            S_WAIT: begin
                if (abort) begin
                    state_d = dir_q ? S_FLOODED : S_IDLE;
                    rem_d   = '0;
                    pre_d   = '0;
                end else if (expire) begin
                    state_d = dir_q ? S_DRAIN : S_FILL;
                    rem_d   = dir_q ? DRAIN_LD : FILL_LD;
                    pre_d   = '0;
                end
            end
            S_FILL: begin
                if (expire) begin
                    state_d = S_FLOODED;
                    rem_d   = '0;
                    pre_d   = '0;
                    done_d  = 1'b1;
                end
            end
            S_DRAIN: begin
                if (expire) begin
                    state_d = S_IDLE;
                    rem_d   = '0;
                    pre_d   = '0;
                    done_d  = 1'b1;
                end
            end
            S_FAULT: begin
                rem_d = '0;
                pre_d = '0;
            end
            default: begin
                state_d = S_IDLE;
                rem_d   = '0;
                pre_d   = '0;
            end
        endcase

`ifdef AIRLOCK_SEQ_FAULT_EN
        // A door switch during a timed phase overrides abort and expiry.
        if (timed && (inner_sw || outer_sw)) begin
            state_d = S_FAULT;
            rem_d   = '0;
            pre_d   = '0;
            done_d  = 1'b0;
        end
`endif
    end

    // Outputs decoded from the registered state; doors gate the live switches.
    assign inner_door = inner_sw && (state_q == S_IDLE);
    assign outer_door = outer_sw && (state_q == S_FLOODED);
    assign waiting    = (state_q == S_WAIT);
    assign filling    = (state_q == S_FILL);
    assign draining   = (state_q == S_DRAIN);
    assign remaining  = rem_q;
    assign done       = done_q;
    assign state      = state_q;

endmodule

// File: tb/tb_airlock_seq.sv
// Self-checking bench for airlock_seq (TICK_DIV=4, default durations).
// The reference model tracks each timed phase as a budget of clock cycles
// and derives the displayed seconds by ceiling division.
module tb_airlock_seq;

    localparam int TD    = 4;
    localparam int WS    = 5;
    localparam int FS    = 7;
    localparam int DS    = 8;
    localparam int CW    = 4;

    logic          clk = 1'b0;
    logic          reset;
    logic          fill_req, drain_req, abort, hold, inner_sw, outer_sw;
    logic          inner_door, outer_door, waiting, filling, draining, done;
    logic [CW-1:0] remaining;
    logic [2:0]    state;

    int checks   = 0;
    int failures = 0;
    int cnt_wait, cnt_fill, cnt_drain, cnt_done;

    // Model: phase number, direction, cycles left in the timed phase, done pulse.
    int m_phase;
    int m_dir;
    int m_left;
    int m_done;

    airlock_seq #(
        .TICK_DIV  (TD),
        .WAIT_SECS (WS),
        .FILL_SECS (FS),
        .DRAIN_SECS(DS),
        .CNT_W     (CW)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .fill_req  (fill_req),
        .drain_req (drain_req),
        .abort     (abort),
        .hold      (hold),
        .inner_sw  (inner_sw),
        .outer_sw  (outer_sw),
        .inner_door(inner_door),
        .outer_door(outer_door),
        .waiting   (waiting),
        .filling   (filling),
        .draining  (draining),
        .remaining (remaining),
        .done      (done),
        .state     (state)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input int got, input int exp);
        checks++;
        if (got != exp) begin
            failures++;
            $display("FAIL %s got=%0d exp=%0d at %0t", name, got, exp, $time);
        end
    endtask

    function automatic bit m_timed();
        return (m_phase == 1) || (m_phase == 2) || (m_phase == 4);
    endfunction

    task automatic model_reset();
        m_phase = 0;
        m_dir   = 0;
        m_left  = 0;
        m_done  = 0;
    endtask

    // Advance the model by one clock edge using the inputs seen at that edge.
    task automatic model_update();
        m_done = 0;
        if (reset) begin
            model_reset();
            return;
        end
`ifdef AIRLOCK_SEQ_FAULT_EN
        if (m_timed() && (inner_sw || outer_sw)) begin
            m_phase = 5;
            m_left  = 0;
            return;
        end
`endif
        case (m_phase)
            0: if (fill_req && !inner_sw && !outer_sw) begin
                m_phase = 1; m_dir = 0; m_left = WS * TD;
            end
            3: if (drain_req && !inner_sw && !outer_sw) begin
                m_phase = 1; m_dir = 1; m_left = WS * TD;
            end
            1: begin
                if (abort) begin
                    m_phase = (m_dir == 1) ? 3 : 0;
                    m_left  = 0;
                end else if (!hold) begin
                    m_left--;
                    if (m_left == 0) begin
                        m_phase = (m_dir == 1) ? 4 : 2;
                        m_left  = ((m_dir == 1) ? DS : FS) * TD;
                    end
                end
            end
            2, 4: if (!hold) begin
                m_left--;
                if (m_left == 0) begin
                    m_phase = (m_phase == 2) ? 3 : 0;
                    m_done  = 1;
                end
            end
            default: ;
        endcase
    endtask

    // Compare every DUT output against the model.
    task automatic compare();
        int exp_rem;
        exp_rem = m_timed() ? (m_left + TD - 1) / TD : 0;
        chk("state",      int'(state),      m_phase);
        chk("remaining",  int'(remaining),  exp_rem);
        chk("done",       int'(done),       m_done);
        chk("waiting",    int'(waiting),    int'(m_phase == 1));
        chk("filling",    int'(filling),    int'(m_phase == 2));
        chk("draining",   int'(draining),   int'(m_phase == 4));
        chk("inner_door", int'(inner_door), int'(inner_sw && m_phase == 0));
        chk("outer_door", int'(outer_door), int'(outer_sw && m_phase == 3));
        if (waiting)  cnt_wait++;
        if (filling)  cnt_fill++;
        if (draining) cnt_drain++;
        if (done)     cnt_done++;
    endtask

    task automatic step();
        @(posedge clk);
        model_update();
        @(negedge clk);
        compare();
    endtask

    task automatic clear_counts();
        cnt_wait = 0; cnt_fill = 0; cnt_drain = 0; cnt_done = 0;
    endtask

    // Step until the chamber leaves the timed phases (bounded).
    task automatic run_phase(input string name);
        int n;
        n = 0;
        while ((waiting || filling || draining) && n < 300) begin
            step();
            n++;
        end
        chk(name, int'(n < 300), 1);
    endtask

    task automatic wait_rem(input string name, input int phase, input int rem);
        int n;
        n = 0;
        while (!(int'(state) == phase && int'(remaining) == rem) && n < 300) begin
            step();
            n++;
        end
        chk(name, int'(n < 300), 1);
    endtask

    initial begin
        reset = 1'b1; fill_req = 0; drain_req = 0; abort = 0; hold = 0;
        inner_sw = 0; outer_sw = 0;
        model_reset();
        clear_counts();
        step();
        step();
        chk("rst_state", int'(state), 0);
        chk("rst_remaining", int'(remaining), 0);
        chk("rst_done", int'(done), 0);
        reset = 1'b0;
        step();

        // Inner door follows its switch in IDLE.
        inner_sw = 1'b1;
        #1 chk("idle_inner_door", int'(inner_door), 1);
        step();
        inner_sw = 1'b0;
        step();

        // Fill cycle: 20 wait cycles, 28 fill cycles, single done pulse.
        clear_counts();
        fill_req = 1'b1;
        step();
        fill_req = 1'b0;
        chk("wait_first_rem", int'(remaining), 5);
        while (waiting && cnt_wait < 100) step();
        chk("fill_first_rem", int'(remaining), 7);
        run_phase("fill_bound");
        chk("fill_wait_cycles", cnt_wait, 20);
        chk("fill_cycles", cnt_fill, 28);
        chk("flooded_state", int'(state), 3);
        chk("flooded_done", int'(done), 1);
        step();
        step();
        chk("fill_done_count", cnt_done, 1);
        chk("flooded_rem", int'(remaining), 0);

        // Outer door usable only when flooded.
        outer_sw = 1'b1;
        #1 chk("flood_outer_door", int'(outer_door), 1);
        chk("flood_inner_door", int'(inner_door), 0);
        step();
        outer_sw = 1'b0;
        step();

        // Drain cycle: 20 wait cycles, 32 drain cycles, done pulse, IDLE.
        clear_counts();
        drain_req = 1'b1;
        step();
        drain_req = 1'b0;
        run_phase("drain_bound");
        chk("drain_wait_cycles", cnt_wait, 20);
        chk("drain_cycles", cnt_drain, 32);
        chk("drain_end_state", int'(state), 0);
        chk("drain_done", int'(done), 1);
        step();

        // Abort from WAIT toward FILL returns to IDLE.
        fill_req = 1'b1;
        step();
        fill_req = 1'b0;
        wait_rem("abort_fill_bound", 1, 3);
        abort = 1'b1;
        step();
        abort = 1'b0;
        chk("abort_idle_state", int'(state), 0);
        chk("abort_idle_rem", int'(remaining), 0);

        // Reach FLOODED, then abort a drain wait back to FLOODED.
        fill_req = 1'b1;
        step();
        fill_req = 1'b0;
        run_phase("abort_prep_bound");
        step();
        drain_req = 1'b1;
        step();
        drain_req = 1'b0;
        wait_rem("abort_drain_bound", 1, 3);
        abort = 1'b1;
        step();
        abort = 1'b0;
        chk("abort_flood_state", int'(state), 3);
        chk("abort_flood_rem", int'(remaining), 0);

        // Hold during FILL stretches it to 38 cycles.
        drain_req = 1'b1;
        step();
        drain_req = 1'b0;
        run_phase("hold_prep_bound");
        step();
        clear_counts();
        fill_req = 1'b1;
        step();
        fill_req = 1'b0;
        wait_rem("hold_reach_bound", 2, 4);
        hold = 1'b1;
        for (int i = 0; i < 10; i++) begin
            step();
            chk("hold_rem", int'(remaining), 4);
        end
        hold = 1'b0;
        run_phase("hold_fill_bound");
        chk("hold_fill_cycles", cnt_fill, 38);
        chk("hold_end_state", int'(state), 3);

        // Asynchronous reset mid-DRAIN.
        step();
        drain_req = 1'b1;
        step();
        drain_req = 1'b0;
        wait_rem("rst_drain_bound", 4, 2);
        #2 reset = 1'b1;
        #1;
        chk("async_rst_state", int'(state), 0);
        chk("async_rst_rem", int'(remaining), 0);
        model_reset();
        step();
        reset = 1'b0;
        step();

`ifdef AIRLOCK_SEQ_FAULT_EN
        // Switch during FILL latches FAULT; requests ignored until reset.
        fill_req = 1'b1;
        step();
        fill_req = 1'b0;
        wait_rem("fault_reach_bound", 2, 6);
        inner_sw = 1'b1;
        step();
        chk("fault_state", int'(state), 5);
        chk("fault_inner_door", int'(inner_door), 0);
        inner_sw = 1'b0;
        fill_req = 1'b1;
        step();
        step();
        chk("fault_sticky", int'(state), 5);
        fill_req = 1'b0;
        reset = 1'b1;
        step();
        reset = 1'b0;
        step();
`endif

        // Randomised traffic against the model.
        for (int i = 0; i < 4000; i++) begin
            fill_req  = ($urandom_range(99) < 30);
            drain_req = ($urandom_range(99) < 30);
            abort     = ($urandom_range(99) < 3);
            hold      = ($urandom_range(99) < 10);
            inner_sw  = ($urandom_range(99) < 8);
            outer_sw  = ($urandom_range(99) < 8);
            reset     = ($urandom_range(999) < 3);
            step();
        end
        reset = 1'b0;
        step();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
